// File: rtl/uart_pkg.sv
// Shared UART constants: receiver framing parameters and the RX FIFO defaults
// derived from them.
package uart_pkg;

  localparam int SIZE_DATA   = 16;
  localparam int OVER_SAMPLE = 16;

  localparam int FIFO_DATA_W = SIZE_DATA;
  localparam int FIFO_DEPTH  = 16;

endpackage : uart_pkg

// File: rtl/uart_fifo_ram.sv
// Simple dual-port storage for the RX FIFO: synchronous write, asynchronous
// read address. Contents are intentionally not reset.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];

endmodule : uart_fifo_ram

// File: rtl/uart_rx_fifo.sv
// First-word fall-through FIFO buffering received UART words, with
// wrap-bit pointers, full/almost-full flags and a sticky overflow flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int AFULL_LVL = DEPTH - 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_en,
  input  logic [DATA_W-1:0]        i_wr_data,
  output logic                     o_valid,
  output logic [DATA_W-1:0]        o_data,
  input  logic                     i_ready,
  output logic                     o_full,
  output logic                     o_afull,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  input  logic                     i_ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AFULL_THR = PW'(AFULL_LVL);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt, cnt_nxt;
  logic          valid_q, full_q, afull_q, ovf_q;
  logic          do_wr, do_rd, drop;

  assign do_rd = valid_q & i_ready;
  assign do_wr = i_wr_en & (~full_q | do_rd);
  assign drop  = i_wr_en & full_q & ~do_rd;

  assign wr_ptr_nxt = wr_ptr + PW'(do_wr);
  assign rd_ptr_nxt = rd_ptr + PW'(do_rd);
  assign cnt_nxt    = wr_ptr_nxt - rd_ptr_nxt;

  // Flags are registered from the next-state pointers so they stay equal to
  // the pointer-derived empty/full/level decode while being glitch-free.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      valid_q <= (wr_ptr_nxt != rd_ptr_nxt);
      full_q  <= (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                 (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
      afull_q <= (cnt_nxt >= AFULL_THR);
      if (drop)           ovf_q <= 1'b1;
      else if (i_ovf_clr) ovf_q <= 1'b0;
    end
  end

  uart_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (do_wr),
    .i_waddr (wr_ptr[AW-1:0]),
    .i_wdata (i_wr_data),
    .i_raddr (rd_ptr[AW-1:0]),
    .o_rdata (o_data)
  );

  assign o_valid    = valid_q;
  assign o_full     = full_q;
  assign o_afull    = afull_q;
  assign o_count    = wr_ptr - rd_ptr;
  assign o_overflow = ovf_q;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model checked
// every cycle, plus directed literal checks and randomized traffic.
module tb_uart_rx_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AFL   = DEPTH - 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          ready = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          valid, full, afull, overflow;
  logic [DW-1:0] data;
  logic [4:0]    count;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] q[$];
  bit            m_ovf = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DATA_W    (DW),
    .DEPTH     (DEPTH),
    .AFULL_LVL (AFL)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_wr_en    (wr_en),
    .i_wr_data  (wr_data),
    .o_valid    (valid),
    .o_data     (data),
    .i_ready    (ready),
    .o_full     (full),
    .o_afull    (afull),
    .o_count    (count),
    .o_overflow (overflow),
    .i_ovf_clr  (ovf_clr)
  );

  // Reference model: pop, then push, from the rules on the current occupancy.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      bit rd, wr, drp;
      rd  = (q.size() > 0) && ready;
      wr  = wr_en && ((q.size() < DEPTH) || rd);
      drp = wr_en && !wr;
      if (rd) void'(q.pop_front());
      if (wr) q.push_back(wr_data);
      if (drp) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
  end

  function automatic void chk(string name, longint act, longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", valid, q.size() != 0);
      chk("m_count", count, q.size());
      chk("m_full",  full,  q.size() == DEPTH);
      chk("m_afull", afull, q.size() >= AFL);
      chk("m_ovf",   overflow, m_ovf);
      if (q.size() != 0) chk("m_data", data, q[0]);
    end
  end

  task automatic step(input bit we, input logic [DW-1:0] d, input bit rdy, input bit clr);
    wr_en = we; wr_data = d; ready = rdy; ovf_clr = clr;
    @(posedge clk);
    #2;
    wr_en = 1'b0; ready = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [DW-1:0] exp_next;
    do_reset();
    chk_en = 1'b1;
    chk("rst_count", count, 0);
    chk("rst_valid", valid, 0);
    chk("rst_full", full, 0);
    chk("rst_afull", afull, 0);
    chk("rst_ovf", overflow, 0);

    // Single write, first edge after reset
    step(1, 16'hA5C3, 0, 0);
    chk("w1_valid", valid, 1);
    chk("w1_data", data, 16'hA5C3);
    chk("w1_count", count, 1);
    step(0, '0, 1, 0);
    chk("w1_drain", count, 0);

    // Fill to full
    for (int i = 1; i <= 16; i++) begin
      step(1, DW'(i), 0, 0);
      chk("fill_count", count, i);
      chk("fill_afull", afull, (i >= 14) ? 1 : 0);
    end
    chk("fill_full", full, 1);

    // Dropped write, then drop coinciding with clear: set wins
    step(1, 16'hDEAD, 0, 0);
    chk("drop_ovf", overflow, 1);
    chk("drop_count", count, 16);
    step(1, 16'hBEEF, 0, 1);
    chk("drop_clr_ovf", overflow, 1);
    for (int i = 1; i <= 16; i++) begin
      chk("drain_data", data, i);
      step(0, '0, 1, 0);
    end
    chk("drain_count", count, 0);
    chk("drain_valid", valid, 0);
    step(0, '0, 0, 1);
    chk("clr_ovf", overflow, 0);

    // Simultaneous write and read while full
    for (int i = 1; i <= 16; i++) step(1, DW'(i), 0, 0);
    step(1, 16'h0011, 1, 0);
    chk("wr_rd_full_count", count, 16);
    chk("wr_rd_full_full", full, 1);
    chk("wr_rd_full_ovf", overflow, 0);
    for (int i = 0; i < 15; i++) step(0, '0, 1, 0);
    chk("last_word", data, 16'h0011);
    step(0, '0, 1, 0);
    chk("empty_again", valid, 0);

    // Steady occupancy of 3 across pointer wrap
    for (int i = 0; i < 3; i++) step(1, 16'h1000 + DW'(i), 0, 0);
    exp_next = 16'h1000;
    for (int i = 3; i < 43; i++) begin
      chk("wrap_order", data, exp_next);
      exp_next++;
      step(1, 16'h1000 + DW'(i), 1, 0);
      chk("wrap_count", count, 3);
      chk("wrap_nofull", full, 0);
    end

    // Drain, then ready while empty must be ignored
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 1, 0);
      chk("underflow_count", count, 0);
    end

    // Randomized traffic with varying write/read bias
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 400; c++) begin
        int wp, rp;
        wp = (ph == 0) ? 80 : (ph == 1) ? 50 : 30;
        rp = (ph == 0) ? 30 : (ph == 1) ? 50 : 80;
        step($urandom_range(0, 99) < wp, DW'($urandom), $urandom_range(0, 99) < rp,
             $urandom_range(0, 99) < 4);
      end
    end

    // Asynchronous reset with words stored
    do_reset();
    for (int i = 0; i < 5; i++) step(1, DW'($urandom), 0, 0);
    chk("pre_rst_count", count, 5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_valid", valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 16'h5A5A, 0, 0);
    chk("post_rst_data", data, 16'h5A5A);
    step(0, '0, 0, 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_uart_rx_fifo
